// File: rtl/comparador_serial_izq_der_if.sv
// Bit-serial comparator bus: operand bit pairs and control in, registered result out.
// The source side (shift register / serial link) uses the master modport,
// the comparator uses the slave modport.
interface comparador_serial_izq_der_if #(
    parameter int N = 4
);
    localparam int CW = $clog2(N + 1);

    logic          start;
    logic          bit_valid;
    logic          A;
    logic          B;
    logic          busy;
    logic          done;
    logic          Z;
    logic          EQ;
    logic          LT;
    logic [CW-1:0] bit_count;

    modport master (
        output start, bit_valid, A, B,
        input  busy, done, Z, EQ, LT, bit_count
    );

    modport slave (
        input  start, bit_valid, A, B,
        output busy, done, Z, EQ, LT, bit_count
    );
endinterface

// File: rtl/comparador_serial_izq_der.sv
// comparador_serial_izq_der: MSB-first serial magnitude comparator.
// One clocked cell is reused over N accepted bit pairs; the first differing pair
// decides the relation, later pairs cannot change it.
// Optional macro COMPARE_EARLY_DONE_EN: finish as soon as the first differing pair
// is seen (equal words still consume all N pairs).
module comparador_serial_izq_der #(
    parameter int N = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    comparador_serial_izq_der_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_GT = 2'd1,
        REL_LT = 2'd2
    } rel_t;

    state_t        state_q, state_d;
    rel_t          rel_q, rel_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          z_q, z_d;
    logic          eq_q, eq_d;
    logic          lt_q, lt_d;

    logic [CW-1:0] count_inc_s;
    logic          last_pair_s;
    logic          decide_s;

    // Increment of the pair counter and the "this pair finishes the word" flag.
    always_comb begin
        count_inc_s = count_q + CW'(1);
        last_pair_s = (count_inc_s == CW'(N));
        decide_s    = (rel_q == REL_EQ) && (bus.A != bus.B);
    end

    // Next-state and next-output logic; all outputs are derived from the next state.
    always_comb begin
        state_d = state_q;
        rel_d   = rel_q;
        count_d = count_q;
        z_d     = z_q;
        eq_d    = eq_q;
        lt_d    = lt_q;

        case (state_q)
            S_IDLE: begin
                // Bits presented together with start are not part of the word.
                if (bus.start) begin
                    state_d = S_RUN;
                    rel_d   = REL_EQ;
                    count_d = {CW{1'b0}};
                    z_d     = 1'b0;
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.bit_valid) begin
                    count_d = count_inc_s;
                    if (decide_s) begin
                        rel_d = bus.A ? REL_GT : REL_LT;
                    end else begin
                        rel_d = rel_q;
                    end
`ifdef COMPARE_EARLY_DONE_EN
                    if (last_pair_s || decide_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
`else
                    if (last_pair_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
`endif
                end else begin
                    // Stall: no timeout, everything holds.
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                // start seen here is dropped; it has to be re-presented in IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rel_d   = REL_EQ;
                count_d = {CW{1'b0}};
                z_d     = 1'b0;
                eq_d    = 1'b0;
                lt_d    = 1'b0;
            end
        endcase

        // Result flags are loaded on the edge that enters DONE.
        if ((state_d == S_DONE) && (state_q == S_RUN)) begin
            z_d  = (rel_d == REL_GT);
            eq_d = (rel_d == REL_EQ);
            lt_d = (rel_d == REL_LT);
        end else begin
            z_d  = z_d;
            eq_d = eq_d;
            lt_d = lt_d;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rel_q   <= REL_EQ;
            count_q <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rel_q   <= rel_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.Z         = z_q;
    assign bus.EQ        = eq_q;
    assign bus.LT        = lt_q;
    assign bus.bit_count = count_q;
endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// Bench for comparador_serial_izq_der (N=4). Expected results are computed from the
// operand words when a comparison is started, queued, and checked when done pulses.
// Honours COMPARE_EARLY_DONE_EN for the expected pair count.
module tb_comparador_serial_izq_der;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    typedef struct {
        logic          gt;
        logic          eq;
        logic          lt;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   total;
    int   passed;

    comparador_serial_izq_der_if #(.N(N)) bus ();

    comparador_serial_izq_der #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: relation of the two words and number of pairs consumed.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        bit   found;
        e.gt  = (a > b);
        e.eq  = (a == b);
        e.lt  = (a < b);
        e.cnt = CW'(N);
        found = 1'b0;
`ifdef COMPARE_EARLY_DONE_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && (a[i] != b[i])) begin
                e.cnt = CW'(N - i);
                found = 1'b1;
            end
        end
`endif
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.bit_valid = 1'b0; bus.A = 1'b0; bus.B = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.Z, bus.EQ, bus.LT} !== 5'b00000 || bus.bit_count !== '0) begin
            $display("FAIL reset: busy/done/Z/EQ/LT=%b%b%b%b%b bit_count=%0d, required all 0",
                     bus.busy, bus.done, bus.Z, bus.EQ, bus.LT, bus.bit_count);
        end else passed++;
    endtask

    // One complete comparison. stall alternates valid/idle cycles, start_in_run pulses
    // start during the idle cycles, and the start cycle carries a misleading valid pair.
    task automatic test_compare(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                                input bit stall);
        exp_t e;
        exp_t got;
        int   acc;
        int   cyc;
        bit   skip;
        e = model(a, b);
        exp_q.push_back(e);

        // Start cycle with a valid pair that would decide A<B if it were consumed.
        bus.start = 1'b1; bus.bit_valid = 1'b1; bus.A = 1'b0; bus.B = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.bit_count !== '0 ||
            {bus.Z, bus.EQ, bus.LT} !== 3'b000) begin
            $display("FAIL %s start: busy=%b done=%b cnt=%0d ZEL=%b%b%b, required 1 0 0 000",
                     name, bus.busy, bus.done, bus.bit_count, bus.Z, bus.EQ, bus.LT);
        end else passed++;

        acc  = 0;
        cyc  = 0;
        skip = stall;
        while (acc < int'(e.cnt) && cyc < 64) begin
            cyc++;
            if (skip) begin
                bus.bit_valid = 1'b0; bus.start = 1'b1;
                bus.A = 1'b0; bus.B = 1'b1;
            end else begin
                bus.bit_valid = 1'b1; bus.start = 1'b0;
                bus.A = a[N-1-acc]; bus.B = b[N-1-acc];
                acc++;
            end
            if (stall) skip = ~skip;
            @(negedge clk);
            bus.start = 1'b0;
            if (acc < int'(e.cnt)) begin
                total++;
                if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.bit_count !== CW'(acc)) begin
                    $display("FAIL %s run: done=%b busy=%b cnt=%0d, required 0 1 %0d",
                             name, bus.done, bus.busy, bus.bit_count, acc);
                end else passed++;
            end
        end
        bus.bit_valid = 1'b0;

        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard: queue empty, required one entry", name);
        end else begin
            got = exp_q.pop_front();
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.Z !== got.gt || bus.EQ !== got.eq ||
                bus.LT !== got.lt || bus.bit_count !== got.cnt) begin
                $display("FAIL %s result: done=%b busy=%b ZEL=%b%b%b cnt=%0d, required 1 0 %b%b%b %0d",
                         name, bus.done, bus.busy, bus.Z, bus.EQ, bus.LT, bus.bit_count,
                         got.gt, got.eq, got.lt, got.cnt);
            end else passed++;

            // start during DONE is dropped; the result holds afterwards.
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            @(negedge clk);
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Z !== got.gt || bus.EQ !== got.eq ||
                bus.LT !== got.lt || bus.bit_count !== got.cnt) begin
                $display("FAIL %s hold: done=%b busy=%b ZEL=%b%b%b cnt=%0d, required 0 0 %b%b%b %0d",
                         name, bus.done, bus.busy, bus.Z, bus.EQ, bus.LT, bus.bit_count,
                         got.gt, got.eq, got.lt, got.cnt);
            end else passed++;
        end
    endtask

    task automatic test_rst_abort();
        logic [N-1:0] w;
        w = 4'b0110;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.bit_valid = 1'b1; bus.A = w[N-1-i]; bus.B = w[N-1-i];
            @(negedge clk);
        end
        bus.bit_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus.busy, bus.done, bus.Z, bus.EQ, bus.LT} !== 5'b00000 || bus.bit_count !== '0) begin
            $display("FAIL abort: busy/done/Z/EQ/LT=%b%b%b%b%b cnt=%0d, required all 0",
                     bus.busy, bus.done, bus.Z, bus.EQ, bus.LT, bus.bit_count);
        end else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                $display("FAIL abort_idle: done=%b busy=%b, required 0 0", bus.done, bus.busy);
            end else passed++;
        end
        bus.bit_valid = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_compare("gt",       4'b1011, 4'b1001, 1'b0);
        test_compare("eq",       4'b0110, 4'b0110, 1'b0);
        test_compare("lt",       4'b0100, 4'b1000, 1'b0);
        test_compare("gt_stall", 4'b1011, 4'b1001, 1'b1);
        test_rst_abort();
        test_compare("after_rst", 4'b1110, 4'b1101, 1'b0);
        test_compare("b2b_max",   4'b1111, 4'b0000, 1'b0);
        test_compare("b2b_lsb",   4'b0000, 4'b0001, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
